simple_cache: RTL
=================

Name: simple_cache

Overview:
Direct-mapped, write-through, one-word-per-line cache that sits between a CPU-side request port and the single-port word RAM.
- It is the initiator end of the RAM's change-detect handshake: it drives the address/data/write tuple, waits for response to rise then fall, and captures read data.
- Read misses fill the line.
- Writes always go through to RAM (write-no-allocate; a write hit also updates the line).

Parameters:
LINES, 16, number of cache lines (power of 2, ≥2)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 64, max cycles waiting for mem_response to rise before aborting

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  request valid; sampled only while cpu_ready=1
cpu_write  in  1  1=write, 0=read
cpu_address  in  ADDR_W  word address
cpu_wdata  in  DATA_W  write data
cpu_ready  out  1  1 in IDLE only
cpu_done  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid while cpu_done=1
cpu_error  out  1  qualifies cpu_done: transaction timed out
mem_address  out  ADDR_W  RAM address
mem_data  out  DATA_W  RAM write data
mem_write  out  1  RAM write enable
mem_response  in  1  RAM busy/ack flag
mem_out  in  DATA_W  RAM read data

Behaviour:
- Reset (async, rst_n=0):
  - all valid bits 0; state IDLE; cpu_ready=1; cpu_done=0; cpu_error=0; cpu_rdata=0; mem_* outputs 0; timeout counter 0.
  - first_txn flag set.
- Index = cpu_address[log2(LINES)-1:0]; tag = remaining upper bits. All outputs registered.
- RAM handshake: the RAM latches a tuple change on the next edge and raises response. On the following edge with the tuple unchanged it performs the op, drops response, and updates mem_out (reads). An unchanged tuple never starts a transaction.
- Repeat rule: the block keeps last-issued tuple regs. If the new tuple equals last, or first_txn=1, it enters PERTURB: drives mem_data = ~data for one cycle, then the real tuple. first_txn clears on the first issue.
- State machine:
  - IDLE: on cpu_req, latch request.
    - Read hit: cpu_rdata = line data, cpu_done=1 for the cycle after accept edge E; stay IDLE.
    - Otherwise: go ISSUE or PERTURB. Tuple is registered at edge E.
  - PERTURB: one cycle, then ISSUE with the real tuple.
  - ISSUE (wait ack): count cycles.
    - mem_response=1 → WAIT_DONE.
    - Count reaches TIMEOUT → cpu_done=1, cpu_error=1, no line update, go IDLE.
  - WAIT_DONE: mem_response=0 → complete, then go IDLE.
    - Read: cpu_rdata=mem_out; line data/tag written; valid=1.
    - Write: line data updated only if hit.
    - Pulse cpu_done.
- Latency from accept edge E, no perturb:
  - response rises E+1, falls E+2.
  - cpu_done high in the cycle after E+3.
  - Perturb adds 1 cycle.
- Tuple is held stable from ISSUE until completion. mem_write never toggles inside a transaction except during PERTURB.
- cpu_req while busy is ignored; cpu_done is never asserted for two consecutive requests without a ready cycle between.
- Reset mid-transaction: abort immediately, invalidate all lines, set first_txn, so the next RAM transaction always perturbs (RAM history unknown).
- Address width: cpu_address passes through unmodified; wrap within RAM size is the RAM's concern.

Test Plan:
- After reset, read 0x00000000 (RAM[0]=0xDEADBEEF) → PERTURB taken; cpu_done with rdata 0xDEADBEEF; cpu_done in the cycle after E+4.
- Repeat the same read → hit; cpu_done the cycle after E; no mem_* change.
- Write 0x5 data 0x12345678, then the identical write again → second write perturbs; RAM[5]=0x12345678; each completes with cpu_error=0.
- Write miss to 0x13 (LINES=16) then read 0x13 → read misses, RAM returns written value, line filled.
- Addresses 0x02 and 0x12 alternate reads → each evicts the other; every access is a miss with correct data.
- Tie mem_response=0, issue read → cpu_done with cpu_error=1 after TIMEOUT=64 cycles; then assert rst_n=0 mid-ISSUE → outputs return to reset values immediately.

Source files
------------

// File: rtl/simple_cache.sv
// Direct-mapped write-through cache, one word per line, in front of
// a change-detect handshake RAM (write-no-allocate, read-allocate).
module simple_cache #(
  parameter int LINES   = 16,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write,
  input  logic              mem_response,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - IW;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    PERTURB,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t state;

  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tags  [LINES];
  logic [DATA_W-1:0] lines [LINES];

  logic              first_txn;
  logic              req_write;
  logic              req_hit;
  logic [ADDR_W-1:0] req_address;
  logic [DATA_W-1:0] req_wdata;
  logic [CW-1:0]     count;

  logic [IW-1:0] idx;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] tag;
  logic          hit;
  logic          same;

  assign idx     = cpu_address[IW-1:0];
  assign tag     = cpu_address[ADDR_W-1:IW];
  assign req_idx = req_address[IW-1:0];
  assign hit     = valid[idx] && (tags[idx] == tag);

  // The mem_* registers hold the last issued tuple between transactions.
  assign same = (mem_address == cpu_address) &&
                (mem_data == cpu_wdata) &&
                (mem_write == cpu_write);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      valid       <= '0;
      first_txn   <= 1'b1;
      req_write   <= 1'b0;
      req_hit     <= 1'b0;
      req_address <= '0;
      req_wdata   <= '0;
      count       <= '0;
      cpu_ready   <= 1'b1;
      cpu_done    <= 1'b0;
      cpu_error   <= 1'b0;
      cpu_rdata   <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_write   <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        tags[i]  <= '0;
        lines[i] <= '0;
      end
    end else begin
      cpu_done  <= 1'b0;
      cpu_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            req_write   <= cpu_write;
            req_hit     <= hit;
            req_address <= cpu_address;
            req_wdata   <= cpu_wdata;
            if (!cpu_write && hit) begin
              cpu_done  <= 1'b1;
              cpu_rdata <= lines[idx];
            end else begin
              mem_address <= cpu_address;
              mem_write   <= cpu_write;
              count       <= '0;
              cpu_ready   <= 1'b0;
              first_txn   <= 1'b0;
              // Force a visible tuple change so the RAM always starts.
              if (first_txn || same) begin
                mem_data <= ~cpu_wdata;
                state    <= PERTURB;
              end else begin
                mem_data <= cpu_wdata;
                state    <= ISSUE;
              end
            end
          end
        end
        PERTURB: begin
          mem_data <= req_wdata;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (mem_response) begin
            state <= WAIT_DONE;
          end else if (count == CW'(TIMEOUT - 1)) begin
            cpu_done  <= 1'b1;
            cpu_error <= 1'b1;
            cpu_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!mem_response) begin
            cpu_done  <= 1'b1;
            cpu_ready <= 1'b1;
            state     <= IDLE;
            if (!req_write) begin
              cpu_rdata      <= mem_out;
              lines[req_idx] <= mem_out;
              tags[req_idx]  <= req_address[ADDR_W-1:IW];
              valid[req_idx] <= 1'b1;
            end else if (req_hit) begin
              lines[req_idx] <= req_wdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
